modk_counter: RTL and testbench

- Parametrised modulo-k counter. Successor to the fixed modulo-5 LED counter.
- Width and power-up modulus are parameters; the modulus can also be written at runtime.
- Adds up/down counting, synchronous clear and load, wrap or one-shot mode, a cascade carry and a wrap counter.
- Sits between a board clock/switch source and the LEDR/HEX display logic. Multiple instances chain through carry_out/en.

---
 rtl/modk_counter.sv | 120 ++++++++++++
 tb/tb_modk_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/modk_counter.sv
// modk_counter: parametrised modulo-k counter.
// Counts up or down through 0..k-1 and either wraps or stops at the terminal value.
// The modulus can be rewritten at runtime.
// A combinational carry_out lets several instances chain into a multi-digit counter.
// wrap_cnt counts completed wraps since the last clear.
//
// Edge priority, highest first: sclr, k_wr, sload, enabled step, hold.
// The one-shot state is held in a two-state register. The done output is that
// state decoded, so the state is directly visible on the port list.
module modk_counter #(
    parameter int WIDTH     = 8,
    parameter int DEFAULT_K = 5,
    parameter int WRAP_W    = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic              up_dn,
    input  logic              one_shot,
    input  logic              sclr,
    input  logic              sload,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              k_wr,
    input  logic [WIDTH-1:0]  k_in,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  k_cur,
    output logic              carry_out,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt
);

    // ST_RUN: counting normally. ST_DONE: a one-shot count hit its terminal value.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  q_reg, q_d;
    logic [WIDTH-1:0]  k_reg, k_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;

    // Terminal count is k-1 in WIDTH-bit arithmetic.
    // So k=0 selects the full 0..2^WIDTH-1 range, and k=1 pins the count at 0.
    logic [WIDTH-1:0]  max_val;
    logic              at_max;
    logic              at_zero;
    logic              term;
    logic              step_ok;
    logic              any_ctrl;
    logic [WIDTH-1:0]  load_clamped;

    // Decode the terminal condition and qualify the step request.
    always_comb begin
        max_val      = k_reg - WIDTH'(1);
        at_max       = (q_reg == max_val);
        at_zero      = (q_reg == '0);
        term         = up_dn ? at_max : at_zero;
        step_ok      = en && (state_q == ST_RUN);
        any_ctrl     = sclr || k_wr || sload;
        load_clamped = (load_val > max_val) ? max_val : load_val;
    end

    // The cascade carry is high exactly when this edge wraps the count or sets done.
    assign carry_out = step_ok && term && !any_ctrl;

    // Compute next count, modulus, wrap count and one-shot state in priority order.
    always_comb begin
        q_d     = q_reg;
        k_d     = k_reg;
        wrap_d  = wrap_q;
        state_d = state_q;

        if (sclr) begin
            q_d     = '0;
            wrap_d  = '0;
            state_d = ST_RUN;
        end else if (k_wr) begin
            // The new modulus governs the terminal value from the following edge.
            // wrap_cnt is deliberately kept.
            k_d     = k_in;
            q_d     = '0;
            state_d = ST_RUN;
        end else if (sload) begin
            q_d     = load_clamped;
            state_d = ST_RUN;
        end else if (step_ok) begin
            if (!term) begin
                q_d = up_dn ? (q_reg + WIDTH'(1)) : (q_reg - WIDTH'(1));
            end else if (one_shot) begin
                // Stop on the terminal value. Only sclr, k_wr or sload leaves ST_DONE.
                state_d = ST_DONE;
            end else begin
                q_d    = up_dn ? '0 : max_val;
                wrap_d = wrap_q + WRAP_W'(1);
            end
        end
    end

    // State registers. The asynchronous reset restores the power-up modulus and aborts any count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_reg   <= '0;
            k_reg   <= WIDTH'(DEFAULT_K);
            wrap_q  <= '0;
            state_q <= ST_RUN;
        end else begin
            q_reg   <= q_d;
            k_reg   <= k_d;
            wrap_q  <= wrap_d;
            state_q <= state_d;
        end
    end

    assign q        = q_reg;
    assign k_cur    = k_reg;
    assign wrap_cnt = wrap_q;
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_modk_counter.sv
// tb_modk_counter: directed bench for modk_counter.
// Uses one instance for single-counter behaviour and a two-instance cascade
// for the carry chain. Expected values are hand-derived.
module tb_modk_counter;

    localparam int WIDTH  = 8;
    localparam int WRAP_W = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // ---------------- main instance ----------------
    logic              en, up_dn, one_shot, sclr, sload, k_wr;
    logic [WIDTH-1:0]  load_val, k_in;
    logic [WIDTH-1:0]  q, k_cur;
    logic              carry_out, done;
    logic [WRAP_W-1:0] wrap_cnt;

    modk_counter #(.WIDTH(WIDTH), .DEFAULT_K(5), .WRAP_W(WRAP_W)) u_dut (
        .clock(clock), .reset_n(reset_n), .en(en), .up_dn(up_dn), .one_shot(one_shot),
        .sclr(sclr), .sload(sload), .load_val(load_val), .k_wr(k_wr), .k_in(k_in),
        .q(q), .k_cur(k_cur), .carry_out(carry_out), .done(done), .wrap_cnt(wrap_cnt)
    );

    // ---------------- cascade: low digit carry drives high digit enable ----------------
    logic              casc_en;
    logic [WIDTH-1:0]  lo_q, hi_q, lo_k, hi_k;
    logic              lo_carry, hi_carry, lo_done, hi_done;
    logic [WRAP_W-1:0] lo_wrap, hi_wrap;

    modk_counter #(.WIDTH(WIDTH), .DEFAULT_K(5), .WRAP_W(WRAP_W)) u_lo (
        .clock(clock), .reset_n(reset_n), .en(casc_en), .up_dn(1'b1), .one_shot(1'b0),
        .sclr(1'b0), .sload(1'b0), .load_val('0), .k_wr(1'b0), .k_in('0),
        .q(lo_q), .k_cur(lo_k), .carry_out(lo_carry), .done(lo_done), .wrap_cnt(lo_wrap)
    );

    modk_counter #(.WIDTH(WIDTH), .DEFAULT_K(5), .WRAP_W(WRAP_W)) u_hi (
        .clock(clock), .reset_n(reset_n), .en(lo_carry), .up_dn(1'b1), .one_shot(1'b0),
        .sclr(1'b0), .sload(1'b0), .load_val('0), .k_wr(1'b0), .k_in('0),
        .q(hi_q), .k_cur(hi_k), .carry_out(hi_carry), .done(hi_done), .wrap_cnt(hi_wrap)
    );

    // ---------------- checking ----------------
    int check_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; up_dn = 1'b1; one_shot = 1'b0; sclr = 1'b0; sload = 1'b0;
        k_wr = 1'b0; load_val = '0; k_in = '0;
    endtask

    task automatic pulse_sclr();
        sclr = 1'b1; tick(); sclr = 1'b0;
    endtask

    task automatic write_k(input logic [WIDTH-1:0] k);
        k_wr = 1'b1; k_in = k; tick(); k_wr = 1'b0;
    endtask

    int exp_dn[7] = '{0, 4, 3, 2, 1, 0, 4};
    int exp_k3[4] = '{0, 1, 2, 0};

    initial begin
        idle_inputs();
        casc_en = 1'b0;

        // Reset state
        #12;
        check("rst_q", 32'(q), 0);
        check("rst_k", 32'(k_cur), 5);
        check("rst_done", 32'(done), 0);
        check("rst_wrap", 32'(wrap_cnt), 0);
        reset_n = 1'b1;
        tick();

        // Up count, wrap mode, k=5
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("up_q", 32'(q), i % 5);
            check("up_carry", 32'(carry_out), (i % 5 == 4) ? 1 : 0);
            check("up_wrap", 32'(wrap_cnt), (i >= 5) ? 1 : 0);
            tick();
        end
        check("up_end_q", 32'(q), 2);

        // Down count from 0, k=5
        pulse_sclr();
        check("sclr_wrap", 32'(wrap_cnt), 0);
        up_dn = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("dn_q", 32'(q), exp_dn[i]);
            check("dn_carry", 32'(carry_out), (exp_dn[i] == 0) ? 1 : 0);
            if (i < 6) tick();
        end
        check("dn_wrap", 32'(wrap_cnt), 2);

        // Modulus write at q=4 while counting up: carry is suppressed by k_wr
        up_dn = 1'b1; k_wr = 1'b1; k_in = 8'd3;
        #1;
        check("kwr_carry", 32'(carry_out), 0);
        tick(); k_wr = 1'b0;
        check("kwr_q", 32'(q), 0);
        check("kwr_k", 32'(k_cur), 3);
        check("kwr_wrap_held", 32'(wrap_cnt), 2);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("k3_q", 32'(q), exp_k3[i]);
            if (i < 3) tick();
        end
        check("k3_wrap", 32'(wrap_cnt), 3);

        // k=0: full 0..255 range
        write_k(8'd0);
        check("k0_k", 32'(k_cur), 0);
        for (int i = 0; i < 256; i++) begin
            check("k0_q", 32'(q), i);
            if (i == 255) check("k0_carry", 32'(carry_out), 1);
            tick();
        end
        check("k0_wrapq", 32'(q), 0);
        check("k0_wrap", 32'(wrap_cnt), 4);

        // One-shot, k=5
        write_k(8'd5);
        pulse_sclr();
        one_shot = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("os_q4", 32'(q), 4);
        check("os_carry", 32'(carry_out), 1);
        check("os_done_pre", 32'(done), 0);
        tick();
        check("os_done", 32'(done), 1);
        check("os_hold_q", 32'(q), 4);
        check("os_carry_after", 32'(carry_out), 0);
        tick(); tick();
        check("os_still_q", 32'(q), 4);
        check("os_wrap", 32'(wrap_cnt), 0);
        one_shot = 1'b0;
        tick();
        check("os_toggle_q", 32'(q), 4);
        check("os_toggle_done", 32'(done), 1);
        sload = 1'b1; load_val = 8'd9;
        tick(); sload = 1'b0;
        check("ld_clamp_q", 32'(q), 4);
        check("ld_done", 32'(done), 0);
        en = 1'b0; sload = 1'b1; load_val = 8'd2;
        tick(); sload = 1'b0;
        check("ld_q", 32'(q), 2);

        // Async reset mid-cycle with k=7, q=3, wrap=1
        write_k(8'd7);
        en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("pre_rst_q", 32'(q), 3);
        check("pre_rst_wrap", 32'(wrap_cnt), 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_q", 32'(q), 0);
        check("arst_wrap", 32'(wrap_cnt), 0);
        check("arst_k", 32'(k_cur), 5);
        #3 reset_n = 1'b1;
        tick();
        check("post_rst_q", 32'(q), 1);

        // Simultaneous sclr + k_wr + sload: only the clear takes effect
        tick();
        check("combo_pre_q", 32'(q), 2);
        sclr = 1'b1; k_wr = 1'b1; k_in = 8'd9; sload = 1'b1; load_val = 8'd3;
        tick();
        sclr = 1'b0; k_wr = 1'b0; sload = 1'b0; en = 1'b0;
        check("combo_q", 32'(q), 0);
        check("combo_k", 32'(k_cur), 5);

        // Cascade: high digit steps once per five low steps
        casc_en = 1'b1;
        for (int i = 0; i < 26; i++) begin
            #1;
            check("casc_lo", 32'(lo_q), i % 5);
            check("casc_hi", 32'(hi_q), (i / 5) % 5);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
